vga_draw_arbiter: RTL
=====================

Name: vga_draw_arbiter

Overview:
Shares the single pixel-write port of the VGA adapter (x, y, colour, plot) between three sources: a full-screen clear request and two rectangle-fill requesters (board/piece drawer and cursor/highlight drawer). It accepts one command at a time and rasterises it at one pixel per clock, row-major. Each requester gets an accept pulse and a completion pulse. It sits between the game-logic drawing FSMs and the VGA adapter, and replaces free-running per-source pixel generators.

Parameters:
SCREEN_W, 320, visible width in pixels; x range 0..SCREEN_W-1
SCREEN_H, 240, visible height in pixels; y range 0..SCREEN_H-1
CLEAR_COLOUR, 3'b000, colour used by a clear command

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
clear_req  in  1  level request for a full-screen fill with CLEAR_COLOUR
clear_ack  out  1  one-cycle pulse when the clear command is accepted
clear_done  out  1  one-cycle pulse after the last clear pixel
req0, req1  in  1 each  level request for a rectangle fill
rx0, rx1  in  9 each  rectangle left x
ry0, ry1  in  8 each  rectangle top y
rw0, rw1  in  9 each  rectangle width
rh0, rh1  in  8 each  rectangle height
rc0, rc1  in  3 each  rectangle colour
ack0, ack1  out  1 each  one-cycle accept pulse; command fields are latched on this edge
done0, done1  out  1 each  one-cycle completion pulse
x  out  9  pixel x
y  out  8  pixel y
colour  out  3  pixel colour
plot  out  1  write-enable to the VGA adapter
busy  out  1  high from the accept edge until the edge that sets done

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; x=0, y=0, colour=0; plot, busy and all ack/done outputs = 0; round-robin pointer favours req0. Reset during DRAW abandons the command; no done pulse is issued.
- States:
  - IDLE: arbitrate. Go to DRAW if a command has at least one pixel. Go to FIN if the command is empty.
  - DRAW: emit one pixel per clock.
  - FIN: one cycle; plot=0, done pulse, then return to IDLE.
- Arbitration (IDLE only):
  - clear_req has the highest priority.
  - req0 and req1 are round-robin: the one not granted last wins when both are high.
  - Arbitration happens at most once per command; there is no preemption while busy.
- Accept edge:
  - The winner's fields are latched and its ack is high for exactly that cycle; busy=1.
  - Clear latches the rectangle (0, 0, SCREEN_W, SCREEN_H, CLEAR_COLOUR).
  - A requester must drop its req within the ack cycle. A req still high at the next IDLE arbitration is treated as a new command.
- Clipping at latch:
  - Effective width = min(w, SCREEN_W - x0).
  - Effective height = min(h, SCREEN_H - y0).
  - The command is empty if w==0, h==0, x0>=SCREEN_W or y0>=SCREEN_H. An empty command goes IDLE -> FIN: ack, then done on the next edge, with no plot.
- DRAW timing:
  - The first pixel (x0, y0) is registered on the edge after accept.
  - x increments each cycle. After x0+ew-1, x wraps to x0 and y increments.
  - The pixel after (x0+ew-1, y0+eh-1) is not emitted: that edge enters FIN.
  - plot=1 in every DRAW output cycle. An accepted command of P pixels yields exactly P consecutive plot cycles.
- Completion: in FIN, done of the owner is high for one cycle and busy drops with it. The earliest next accept is on the following edge.
- Output hold: x, y and colour hold their last values when plot=0.
- Latency: accept edge + 1 = first pixel; accept edge + P + 1 = done. A full clear takes 76800 plot cycles.
- Internal counters are sized to hold their maximum (x up to SCREEN_W, y up to SCREEN_H) without overflow. No pixel with x>=SCREEN_W or y>=SCREEN_H is ever plotted.

Test Plan:
- Reset release, req0=1 with (10, 20, 3, 2, 3'b101) -> ack0 one cycle; 6 plot cycles, (10,20) (11,20) (12,20) (10,21) (11,21) (12,21), colour 101; done0 on the following cycle; busy high throughout.
- clear_req, req0 and req1 rise together -> clear granted first; 76800 plots, last at (319,239); then req0 granted; then req1 granted (round-robin).
- req0 and req1 both held continuously -> grants alternate 0,1,0,1; each ack follows the previous done by exactly one cycle.
- req1 with (318, 239, 5, 4, 3'b010) -> clipped to 2 plots, (318,239) and (319,239), then done1.
- req0 with w=0, then req1 with x=320 -> each gives ack, then done on the next cycle, with no plot cycles.
- Assert rst=0 mid-rectangle -> plot, busy and x/y go to 0 asynchronously; no done pulse; a new req0 after release starts cleanly.

Source files
------------

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: arbitrates one clear source and two rectangle-fill sources
// onto the single VGA pixel-write port. One command at a time, rasterised
// row-major at one pixel per clock. All outputs are registered.
module vga_draw_arbiter #(
    parameter int          SCREEN_W     = 320,
    parameter int          SCREEN_H     = 240,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_req,
    output logic        clear_ack,
    output logic        clear_done,
    input  logic        req0,
    input  logic        req1,
    input  logic [8:0]  rx0,
    input  logic [8:0]  rx1,
    input  logic [7:0]  ry0,
    input  logic [7:0]  ry1,
    input  logic [8:0]  rw0,
    input  logic [8:0]  rw1,
    input  logic [7:0]  rh0,
    input  logic [7:0]  rh1,
    input  logic [2:0]  rc0,
    input  logic [2:0]  rc1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DRAW = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

    localparam logic [1:0] OWN_CLR = 2'd0;
    localparam logic [1:0] OWN_R0  = 2'd1;
    localparam logic [1:0] OWN_R1  = 2'd2;

    // Geometry is carried in 10 bits so SCREEN_W / SCREEN_H themselves fit.
    localparam logic [9:0] SCR_W = 10'(SCREEN_W);
    localparam logic [9:0] SCR_H = 10'(SCREEN_H);

    // Clip a span to the screen: zero when it starts off-screen or is empty.
    function automatic logic [9:0] clip_len(input logic [9:0] org,
                                            input logic [9:0] len,
                                            input logic [9:0] lim);
        logic [9:0] avail;
        if ((org >= lim) || (len == 10'd0)) begin
            return 10'd0;
        end else begin
            avail = lim - org;
            return (len < avail) ? len : avail;
        end
    endfunction

    // Registered state and outputs
    state_t      state_r;
    logic [1:0]  owner_r;
    logic        rr_last1_r;      // 1: req1 was granted last, so req0 is favoured
    logic [9:0]  x0_r, xlast_r, ylast_r, cx_r, cy_r;
    logic [2:0]  col_lat_r;
    logic [8:0]  x_r;
    logic [7:0]  y_r;
    logic [2:0]  colour_r;
    logic        plot_r, busy_r;
    logic        clear_ack_r, ack0_r, ack1_r;
    logic        clear_done_r, done0_r, done1_r;

    // Next-state values
    state_t      state_s;
    logic [1:0]  owner_s;
    logic        rr_last1_s;
    logic [9:0]  x0_s, xlast_s, ylast_s, cx_s, cy_s;
    logic [2:0]  col_lat_s;
    logic [8:0]  x_s;
    logic [7:0]  y_s;
    logic [2:0]  colour_s;
    logic        plot_s, busy_s;
    logic        clear_ack_s, ack0_s, ack1_s;
    logic        clear_done_s, done0_s, done1_s;

    // Arbitration and selected command fields
    logic        gnt_clr_s, gnt0_s, gnt1_s;
    logic [9:0]  org_x_s, org_y_s, len_w_s, len_h_s;
    logic [2:0]  col_s;
    logic [9:0]  ew_s, eh_s;

    // Priority/round-robin grant and mux of the winner's command fields.
    always_comb begin
        gnt_clr_s = clear_req;
        gnt0_s    = ~clear_req & req0 & (~req1 | rr_last1_r);
        gnt1_s    = ~clear_req & req1 & (~req0 | ~rr_last1_r);
        org_x_s   = 10'd0;
        org_y_s   = 10'd0;
        len_w_s   = 10'd0;
        len_h_s   = 10'd0;
        col_s     = 3'b000;
        if (gnt_clr_s) begin
            len_w_s = SCR_W;
            len_h_s = SCR_H;
            col_s   = CLEAR_COLOUR;
        end else if (gnt0_s) begin
            org_x_s = {1'b0, rx0};
            org_y_s = {2'b00, ry0};
            len_w_s = {1'b0, rw0};
            len_h_s = {2'b00, rh0};
            col_s   = rc0;
        end else if (gnt1_s) begin
            org_x_s = {1'b0, rx1};
            org_y_s = {2'b00, ry1};
            len_w_s = {1'b0, rw1};
            len_h_s = {2'b00, rh1};
            col_s   = rc1;
        end else begin
            col_s   = 3'b000;
        end
        ew_s = clip_len(org_x_s, len_w_s, SCR_W);
        eh_s = clip_len(org_y_s, len_h_s, SCR_H);
    end

    // FSM next-state and next-output logic.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        rr_last1_s   = rr_last1_r;
        x0_s         = x0_r;
        xlast_s      = xlast_r;
        ylast_s      = ylast_r;
        cx_s         = cx_r;
        cy_s         = cy_r;
        col_lat_s    = col_lat_r;
        x_s          = x_r;
        y_s          = y_r;
        colour_s     = colour_r;
        plot_s       = 1'b0;
        busy_s       = busy_r;
        clear_ack_s  = 1'b0;
        ack0_s       = 1'b0;
        ack1_s       = 1'b0;
        clear_done_s = 1'b0;
        done0_s      = 1'b0;
        done1_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gnt_clr_s | gnt0_s | gnt1_s) begin
                    busy_s      = 1'b1;
                    clear_ack_s = gnt_clr_s;
                    ack0_s      = gnt0_s;
                    ack1_s      = gnt1_s;
                    if (gnt_clr_s) begin
                        owner_s = OWN_CLR;
                    end else if (gnt0_s) begin
                        owner_s    = OWN_R0;
                        rr_last1_s = 1'b0;
                    end else begin
                        owner_s    = OWN_R1;
                        rr_last1_s = 1'b1;
                    end
                    x0_s      = org_x_s;
                    cx_s      = org_x_s;
                    cy_s      = org_y_s;
                    xlast_s   = org_x_s + ew_s - 10'd1;
                    ylast_s   = org_y_s + eh_s - 10'd1;
                    col_lat_s = col_s;
                    if ((ew_s == 10'd0) || (eh_s == 10'd0)) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_DRAW;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAW: begin
                plot_s   = 1'b1;
                x_s      = cx_r[8:0];
                y_s      = cy_r[7:0];
                colour_s = col_lat_r;
                if (cx_r == xlast_r) begin
                    cx_s = x0_r;
                    if (cy_r == ylast_r) begin
                        state_s = ST_FIN;
                    end else begin
                        cy_s = cy_r + 10'd1;
                    end
                end else begin
                    cx_s = cx_r + 10'd1;
                end
            end
            ST_FIN: begin
                busy_s       = 1'b0;
                clear_done_s = (owner_r == OWN_CLR);
                done0_s      = (owner_r == OWN_R0);
                done1_s      = (owner_r == OWN_R1);
                state_s      = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_CLR;
            rr_last1_r   <= 1'b1;
            x0_r         <= 10'd0;
            xlast_r      <= 10'd0;
            ylast_r      <= 10'd0;
            cx_r         <= 10'd0;
            cy_r         <= 10'd0;
            col_lat_r    <= 3'b000;
            x_r          <= 9'd0;
            y_r          <= 8'd0;
            colour_r     <= 3'b000;
            plot_r       <= 1'b0;
            busy_r       <= 1'b0;
            clear_ack_r  <= 1'b0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            clear_done_r <= 1'b0;
            done0_r      <= 1'b0;
            done1_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            rr_last1_r   <= rr_last1_s;
            x0_r         <= x0_s;
            xlast_r      <= xlast_s;
            ylast_r      <= ylast_s;
            cx_r         <= cx_s;
            cy_r         <= cy_s;
            col_lat_r    <= col_lat_s;
            x_r          <= x_s;
            y_r          <= y_s;
            colour_r     <= colour_s;
            plot_r       <= plot_s;
            busy_r       <= busy_s;
            clear_ack_r  <= clear_ack_s;
            ack0_r       <= ack0_s;
            ack1_r       <= ack1_s;
            clear_done_r <= clear_done_s;
            done0_r      <= done0_s;
            done1_r      <= done1_s;
        end
    end

    assign x          = x_r;
    assign y          = y_r;
    assign colour     = colour_r;
    assign plot       = plot_r;
    assign busy       = busy_r;
    assign clear_ack  = clear_ack_r;
    assign ack0       = ack0_r;
    assign ack1       = ack1_r;
    assign clear_done = clear_done_r;
    assign done0      = done0_r;
    assign done1      = done1_r;

endmodule
